// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Fetch/data arbiter onto a single-port word RAM.
// Sub-word stores are done as read-modify-write; bad data accesses complete with d_err.
module mem_arbiter #(
  parameter int MEM_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW, ACK} state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;   // 1 when the data port won the most recent grant
  logic        own_d_q, own_d_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        err_q, err_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;

  logic        grant_i, grant_d, d_bad, we_raw;
  logic [31:0] load_word, merged;
  logic        unused_ok;

  assign unused_ok = ^i_addr[1:0];

  always_comb begin
    d_bad = (d_addr >= MEM_LIMIT);
    case (d_size)
      SZ_BYTE: begin end
      SZ_HALF: if (d_addr[0]) d_bad = 1'b1;
      SZ_WORD: if (d_addr[1:0] != 2'b00) d_bad = 1'b1;
      default: d_bad = 1'b1;
    endcase
  end

  always_comb begin
    load_word = ram_rdata;
    if (size_q == SZ_BYTE) begin
      case (off_q)
        2'd0:    load_word = {24'd0, ram_rdata[7:0]};
        2'd1:    load_word = {24'd0, ram_rdata[15:8]};
        2'd2:    load_word = {24'd0, ram_rdata[23:16]};
        default: load_word = {24'd0, ram_rdata[31:24]};
      endcase
    end else if (size_q == SZ_HALF) begin
      load_word = off_q[1] ? {16'd0, ram_rdata[31:16]} : {16'd0, ram_rdata[15:0]};
    end
  end

  always_comb begin
    merged = ram_rdata;
    if (size_q == SZ_HALF) begin
      if (off_q[1]) merged[31:16] = wdata_q;
      else          merged[15:0]  = wdata_q;
    end else begin
      case (off_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    own_d_d   = own_d_q;
    off_d     = off_q;
    size_d    = size_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    we_raw    = 1'b0;
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
    i_valid   = 1'b0;
    i_rdata   = 32'd0;
    d_valid   = 1'b0;
    d_rdata   = 32'd0;
    d_err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rst) begin
          if (d_req && (!i_req || !last_d_q)) grant_d = 1'b1;
          else if (i_req)                     grant_i = 1'b1;
        end
        if (grant_i) begin
          ram_addr = {i_addr[31:2], 2'b00};
          own_d_d  = 1'b0;
          last_d_d = 1'b0;
          state_d  = RD_WAIT;
        end else if (grant_d) begin
          ram_addr = {d_addr[31:2], 2'b00};
          own_d_d  = 1'b1;
          last_d_d = 1'b1;
          off_d    = d_addr[1:0];
          size_d   = d_size;
          wdata_d  = d_wdata[15:0];
          err_d    = d_bad;
          if (d_bad) begin
            state_d = ACK;
          end else if (!d_we) begin
            state_d = RD_WAIT;
          end else if (d_size == SZ_WORD) begin
            we_raw    = 1'b1;
            ram_wdata = d_wdata;
            state_d   = ACK;
          end else begin
            state_d = RMW;
          end
        end
      end
      RD_WAIT: begin
        if (own_d_q) begin
          d_valid = 1'b1;
          d_rdata = load_word;
        end else begin
          i_valid = 1'b1;
          i_rdata = ram_rdata;
        end
        state_d = IDLE;
      end
      RMW: begin
        we_raw    = 1'b1;
        ram_wdata = merged;
        state_d   = ACK;
      end
      default: begin
        d_valid = 1'b1;
        d_err   = err_q;
        state_d = IDLE;
      end
    endcase

    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
  end

  assign i_ready = grant_i;
  assign d_ready = grant_d;
  assign ram_we  = we_raw & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      own_d_q     <= 1'b0;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      err_q       <= 1'b0;
      wdata_q     <= 16'd0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      own_d_q     <= own_d_d;
      off_q       <= off_d;
      size_q      <= size_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_BYTES, default 16, RAM size in bytes; byte addresses at or above MEM_BYTES are out of range.
REQ-002 clk  in  1  system clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 i_req  in  1  instruction-fetch request; held with i_addr until i_ready.
REQ-005 i_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-006 i_ready  out  1  fetch accepted this cycle.
REQ-007 i_valid  out  1  one-cycle pulse; i_rdata valid.
REQ-008 i_rdata  out  32  fetched word.
REQ-009 d_req  in  1  data request; held with d_we, d_size, d_addr and d_wdata until d_ready.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_size  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-012 d_addr  in  32  data byte address.
REQ-013 d_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-014 d_ready  out  1  data request accepted this cycle.
REQ-015 d_valid  out  1  one-cycle completion pulse for loads and stores.
REQ-016 d_rdata  out  32  load data, zero-extended; 0 for stores and errors.
REQ-017 d_err  out  1  pulses with d_valid on a misaligned, illegal-size or out-of-range access.
REQ-018 ram_we  out  1  RAM write enable.
REQ-019 ram_addr  out  32  RAM byte address; always word-aligned ([1:0] = 00).
REQ-020 ram_wdata  out  32  RAM write data.
REQ-021 ram_rdata  in  32  RAM read data; valid the cycle after ram_addr is presented.

Function
REQ-022 FSM states: IDLE, RD_WAIT, RMW, ACK; requests are accepted only in IDLE.
REQ-023 In IDLE with one requester active, that requester is granted in the same cycle (i_ready or d_ready = 1, combinational).
REQ-024 In IDLE with both requesters active, grant is round-robin: the requester not granted last wins; last_grant resets to I, so D wins the first tie.
REQ-025 On grant, the controller latches the address low bits, size, direction and write data; the requester may change its inputs from the next cycle.
REQ-026 Fetch or load accepted in cycle T:
- ram_addr = {addr[31:2], 2'b00} and ram_we = 0 in cycle T;
- state RD_WAIT in T+1, where the valid pulse is asserted and rdata is taken from ram_rdata;
- return to IDLE at T+2.
REQ-027 Load lane extraction is little-endian:
- byte k = ram_rdata[8k+7:8k];
- halfword at offset 0 = [15:0], at offset 2 = [31:16];
- the result is zero-extended.
REQ-028 Word store accepted in T: ram_we = 1, ram_wdata = d_wdata in T; state ACK in T+1 with d_valid = 1; IDLE at T+2.
REQ-029 Byte/halfword store accepted in T (read-modify-write):
- T: read of the aligned word, ram_we = 0;
- T+1 (RMW): ram_we = 1, ram_wdata = ram_rdata with only the addressed lanes replaced from the latched write data;
- T+2 (ACK): d_valid = 1;
- T+3: IDLE.
REQ-030 Errors: halfword with addr[0] = 1, word with addr[1:0] != 00, d_size = 11, or addr >= MEM_BYTES.
- The request is accepted and ram_we is never asserted.
- d_valid and d_err pulse in T+1 (ACK), with d_rdata = 0.
REQ-031 Fetch errors are not detected; an out-of-range fetch returns whatever ram_rdata holds.
REQ-032 At most one of i_valid and d_valid is asserted in any cycle; i_ready and d_ready are never both 1.
REQ-033 In IDLE with no grant, ram_we = 0 and ram_addr holds its last value.
REQ-034 ram_we is gated by !rst combinationally: no RAM write occurs in any cycle in which rst = 1.

Reset
REQ-035 On a posedge with rst = 1:
- state -> IDLE and last_grant -> I;
- i_ready, d_ready, i_valid, d_valid, d_err, ram_we = 0;
- i_rdata, d_rdata, ram_addr, ram_wdata = 0.
REQ-036 Reset mid-transaction aborts it with no valid or err pulse.
- An RMW aborted before its RMW cycle performs no write.
- RAM contents are not cleared by rst.

Verification
REQ-037 Word store then load, in this order:
- store d_addr = 4, d_size = 10, d_wdata = 0xDEADBEEF;
- load d_addr = 4;
- required: d_rdata = 0xDEADBEEF one cycle after the load grant.
REQ-038 Byte store over an existing word: word 0x11223344 at address 8, then store byte 0xAA at address 10.
- Required: ram_we is high exactly one cycle, with ram_wdata = 0x11AA3344; d_valid occurs 2 cycles after the grant.
- A following halfword load at address 10 returns 0x000011AA.
REQ-039 Simultaneous i_req and d_req held high for 4 grants.
- Required grant order: D, I, D, I.
- Each valid pulse is exactly 1 cycle after its grant; the two valid pulses never overlap.
REQ-040 Error cases, each pulsing d_valid = d_err = 1 in T+1 with no ram_we:
- word store at d_addr = 6;
- byte load at d_addr = 16 (MEM_BYTES = 16).
REQ-041 Reset during RMW: halfword store to address 0 over word 0x55667788, with rst = 1 in the cycle after the grant.
- Required: no write occurs, no d_valid, and a later load from address 0 returns 0x55667788.
